// File: rtl/cbus_sram_slave_pkg.sv
// Shared cbus types and the slave FSM state encoding for cbus_sram_slave.
package cbus_sram_slave_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
        MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
        MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
        MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LAT   = 2'd1,
        S_BEAT  = 2'd2,
        S_DRAIN = 2'd3
    } slave_state_t;

    localparam logic [63:0] OOR_FILL = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/cbus_sram_slave_sram_bytewrite.sv
// WORDS x 64-bit storage with per-byte write enables and an asynchronous read port.
module sram_bytewrite #(
    parameter int WORDS  = 4096,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cbus_sram_slave.sv
// cbus responder backed by on-chip SRAM: single/burst reads, strobed writes, fixed latency.
// Optional out-of-range detection with sticky oor_err when CBUS_SRAM_OOR_CHECK_EN is defined.
module cbus_sram_slave
    import cbus_sram_slave_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
`ifdef CBUS_SRAM_OOR_CHECK_EN
    output logic       oor_err,
`endif
    output logic       busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // With the range check the full word offset is kept so INCR can walk off the end.
`ifdef CBUS_SRAM_OOR_CHECK_EN
    localparam int OFF_W = 61;
`else
    localparam int OFF_W = IDX_W;
`endif
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    function automatic logic [OFF_W-1:0] word_offset(input logic [63:0] addr);
        logic [63:0] off;
        off = (addr - BASE_ADDR) >> 3;
        return OFF_W'(off);
    endfunction

    slave_state_t     state_q, state_d;
    logic [3:0]       beats_q, beats_d;
    logic [3:0]       lat_q, lat_d;
    logic [OFF_W-1:0] word_q, word_d;
    logic             incr_q, incr_d;
    logic             write_q, write_d;

    logic             beat;
    logic             in_range;
    logic             mem_we;
    logic [63:0]      mem_rdata;
    logic             unused_size;

    assign unused_size = ^creq.size;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beats_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            lat_q   <= lat_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q  <= word_d;
        incr_q  <= incr_d;
        write_q <= write_d;
    end

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        lat_d   = lat_q;
        word_d  = word_q;
        incr_d  = incr_q;
        write_d = write_q;
        case (state_q)
            S_IDLE: begin
                if (creq.valid) begin
                    beats_d = creq.len;
                    word_d  = word_offset(creq.addr);
                    incr_d  = (creq.burst == BURST_INCR);
                    write_d = creq.is_write;
                    lat_d   = LAT_INIT;
                    state_d = (LATENCY == 0) ? S_BEAT : S_LAT;
                end
            end
            S_LAT: begin
                lat_d = lat_q - 4'd1;
                if (lat_d == 4'd0) state_d = S_BEAT;
            end
            S_BEAT: begin
                if (beats_q == 4'd0) begin
                    state_d = S_DRAIN;
                end else begin
                    beats_d = beats_q - 4'd1;
                    if (incr_q) word_d = word_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Hold here until the initiator drops valid so the same request is not served twice.
                if (!creq.valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign beat = (state_q == S_BEAT);
    assign busy = (state_q != S_IDLE);

`ifdef CBUS_SRAM_OOR_CHECK_EN
    logic oor_err_q;

    assign in_range = (word_q < OFF_W'(MEM_WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oor_err_q <= 1'b0;
        end else if (beat && !in_range) begin
            oor_err_q <= 1'b1;
        end
    end

    assign oor_err = oor_err_q;
`else
    assign in_range = 1'b1;
`endif

    assign mem_we = beat && write_q && in_range;

    sram_bytewrite #(
        .WORDS  (MEM_WORDS),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (creq.strobe),
        .addr  (word_q[IDX_W-1:0]),
        .wdata (creq.data),
        .rdata (mem_rdata)
    );

    always_comb begin
        cresp = '0;
        if (beat) begin
            cresp.ready = 1'b1;
            cresp.last  = (beats_q == 4'd0);
            if (!write_q) cresp.data = in_range ? mem_rdata : OOR_FILL;
        end
    end

endmodule
